// File: rtl/led_arbiter_pkg.sv
// led_arbiter_pkg: shared widths, mode/state encodings and small helpers
// for the LED arbiter slice.
//   N_REQ      number of requesters (bit 0 = highest priority)
//   LED_W      number of board LEDs
//   mode_e     per-requester display mode
//   state_e    arbiter FSM state
//   lowest_bit isolate the lowest set bit of a request vector
//   mode_mask  per-LED enable mask for a mode at the current blink phase
package led_arbiter_pkg;

   localparam int N_REQ = 3;
   localparam int LED_W = 6;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_SLOW  = 2'd2,
      MODE_FAST  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_e;

   // Two's-complement trick: r & -r keeps only the lowest set bit,
   // which is the highest-priority requester.
   function automatic logic [N_REQ-1:0] lowest_bit(input logic [N_REQ-1:0] r);
      return r & (~r + {{(N_REQ-1){1'b0}}, 1'b1});
   endfunction

   // slow = tick_cnt[5] (64-tick period), fast = tick_cnt[3] (16-tick period)
   function automatic logic [LED_W-1:0] mode_mask(input mode_e m,
                                                  input logic [5:0] tick_cnt);
      case (m)
         MODE_SOLID: return '1;
         MODE_SLOW:  return {LED_W{tick_cnt[5]}};
         MODE_FAST:  return {LED_W{tick_cnt[3]}};
         default:    return '0;
      endcase
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler plus free-running blink phase counter.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tick      one-cycle pulse in the cycle the prescaler wraps
//   tick_cnt  6-bit phase counter, advances on each tick, wraps 63->0
module led_tick_gen #(
   parameter int PRESCALE = 270_000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       tick,
   output logic [5:0] tick_cnt
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] pre_cnt;

   assign tick = (pre_cnt == CW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         tick_cnt <= '0;
      end else if (tick) begin
         pre_cnt  <= '0;
         tick_cnt <= tick_cnt + 6'd1;
      end else begin
         pre_cnt  <= pre_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: shares six active-low LEDs among three requesters under
// fixed priority (bit 0 highest) with a minimum ownership time, and shows
// a heartbeat on led[5] when nobody owns the LEDs.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req          per-requester request
//   req_pattern  requester i pattern on [6i+5:6i], 1 = lit
//   req_mode     requester i mode on [2i+1:2i] (OFF/SOLID/SLOW/FAST)
//   gnt          registered one-hot owner, zero when idle
//   led          registered active-low LED drive
module led_arbiter
   import led_arbiter_pkg::*;
#(
   parameter int CLK_HZ   = 27_000_000,
   parameter int PRESCALE = 270_000,
   parameter int MIN_HOLD = 50
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*LED_W-1:0]  req_pattern,
   input  logic [N_REQ*2-1:0]      req_mode,
   output logic [N_REQ-1:0]        gnt,
   output logic [LED_W-1:0]        led
);

   if (PRESCALE < 2 || MIN_HOLD < 1 || CLK_HZ < 1) begin : g_bad_param
      $error("led_arbiter: PRESCALE must be >= 2 and MIN_HOLD >= 1");
   end

   localparam int HW = $clog2(MIN_HOLD + 1);

   state_e             state, state_n;
   logic [N_REQ-1:0]   gnt_n;
   logic [N_REQ-1:0]   higher;
   logic [HW-1:0]      hold_cnt, hold_n;
   logic               tick;
   logic [5:0]         tick_cnt;
   logic [LED_W-1:0]   own_pat;
   mode_e              own_mode;
   logic [LED_W-1:0]   led_n;

   led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .tick_cnt (tick_cnt)
   );

   // With gnt one-hot, gnt-1 sets every bit below the owner: exactly the
   // requesters that outrank it.
   assign higher = req & (gnt - {{(N_REQ-1){1'b0}}, 1'b1});

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      hold_n  = hold_cnt;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               gnt_n   = lowest_bit(req);
               hold_n  = '0;
               state_n = ST_OWNED;
            end
         end
         ST_OWNED: begin
            if (~|(req & gnt)) begin
               // owner released: plain priority pick, hold rule not involved
               gnt_n   = lowest_bit(req);
               hold_n  = '0;
               state_n = (|req) ? ST_OWNED : ST_IDLE;
            end else if ((|higher) && (hold_cnt == HW'(MIN_HOLD))) begin
               gnt_n  = lowest_bit(higher);
               hold_n = '0;
            end else if (tick && (hold_cnt != HW'(MIN_HOLD))) begin
               hold_n = hold_cnt + {{(HW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            hold_n  = '0;
         end
      endcase
   end

   // Pattern and mode are taken live from the registered owner's inputs.
   always_comb begin
      own_pat  = '0;
      own_mode = MODE_OFF;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            own_pat  = req_pattern[LED_W*i +: LED_W];
            own_mode = mode_e'(req_mode[2*i +: 2]);
         end
      end
      if (state == ST_IDLE)
         led_n = {~tick_cnt[5], {(LED_W-1){1'b1}}};
      else
         led_n = ~(own_pat & mode_mask(own_mode, tick_cnt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         hold_cnt <= '0;
         led      <= '1;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         hold_cnt <= hold_n;
         led      <= led_n;
      end
   end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Shares the board's six active-low LEDs among three requesters (e.g. game status, score flash, debug) under fixed priority with a minimum ownership time. It also generates the blink timing those requesters select. With no requester active it drives a heartbeat on led[5]. Sits between game/debug logic and the top-level `led` pins.

## Interface
- CLK_HZ, 27_000_000: input clock frequency; documentation only, not used in logic.
- PRESCALE, 270_000: clk cycles per tick (100 Hz at 27 MHz). Must be ≥2.
- MIN_HOLD, 50: ticks an owner keeps the LEDs before a higher-priority requester may preempt it. Must be ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  3  request per requester; bit 0 is the highest priority.
- req_pattern  input  18  requester i drives bits [6i+5:6i]; a 1 means the LED is lit.
- req_mode  input  6  requester i drives bits [2i+1:2i]: 0 OFF, 1 SOLID, 2 SLOW, 3 FAST.
- gnt  output  3  one-hot current owner, registered; all zeros when idle.
- led  output  6  LED drive, active-low (0 = lit), registered.

## Operation
- Tick generator:
  - prescale counter runs 0..PRESCALE-1 and wraps.
  - tick pulses for one cycle when the counter wraps.
  - tick_cnt[5:0] is free-running and increments on each tick, wrapping 63→0.
  - fast = tick_cnt[3] (period 16 ticks). slow = tick_cnt[5] (period 64 ticks).
- FSM, IDLE:
  - gnt = 0.
  - If any req bit is set: grant the lowest-index set bit, clear hold_cnt, go to OWNED.
- FSM, OWNED (owner = index of gnt):
  - hold_cnt increments on each tick and saturates at MIN_HOLD.
  - Owner's req drops: re-arbitrate in the same cycle. Grant the highest-priority remaining request with hold_cnt cleared, or go to IDLE if none remain.
  - Owner's req still high, a higher-priority req is high, and hold_cnt == MIN_HOLD: switch to that requester and clear hold_cnt.
  - A lower-priority req never preempts the owner.
  - A higher-priority req arriving before MIN_HOLD waits. Its request stays visible and it wins at the first cycle hold_cnt == MIN_HOLD.
- Output:
  - on = owner_pattern & mask, where mask is 000000 for OFF, 111111 for SOLID, {6{slow}} for SLOW, {6{fast}} for FAST.
  - Pattern and mode are read live from the owner's inputs every cycle; they are not latched at grant time.
  - led = ~on.
  - In IDLE: led = {~slow, 5'b11111}, the heartbeat.
- Reset, applied at any time including mid-ownership: state IDLE, gnt = 000, led = 111111, hold_cnt = 0, prescale counter = 0, tick_cnt = 0.

## Timing
- req sampled at edge N → gnt valid after edge N+1.
- led reflects the new owner's pattern/mode after edge N+2: led is registered from a mux driven by the registered gnt.
- A pattern or mode change by the current owner at edge N appears on led after edge N+1.
- Owner drops req at edge N:
  - next owner's gnt after N+1.
  - if none remain, gnt = 0 after N+1 and heartbeat on led after N+2.
- Preemption occurs on the clock edge after hold_cnt reaches MIN_HOLD, i.e. at least MIN_HOLD×PRESCALE cycles after the grant.
- Simultaneous owner drop and new higher-priority request resolve by normal priority in a single re-arbitration. The hold rule does not apply because the owner has released.
- gnt is always one-hot or zero; there are no glitches between owners.

## Structure
- Package led_arbiter_pkg holds:
  - N_REQ = 3 and LED_W = 6.
  - Mode enum: MODE_OFF, MODE_SOLID, MODE_SLOW, MODE_FAST.
  - FSM state enum: ST_IDLE, ST_OWNED.
- Sub-module led_tick_gen (parameter PRESCALE; outputs tick and tick_cnt[5:0]) holds the prescaler and the phase counter.
- Top level holds the FSM, hold counter, grant register and output mux/register.

## Test plan
Bench settings: PRESCALE = 4, MIN_HOLD = 3.
- Reset: hold rst_n low, then release. Required: led = 111111 and gnt = 000 during reset. led[5] toggles every 128 cycles thereafter and led[4:0] stays 11111.
- Single request: req = 010, pattern1 = 101010, mode1 = SOLID at edge N. Required: gnt = 010 after N+1, led = 010101 after N+2.
- Blink: owner mode = FAST, pattern = 111111. Required: led alternates 000000/111111 every 32 cycles (8 ticks × 4), phase-aligned to tick_cnt[3].
- Hold then preempt: req2 granted, req0 raised 1 tick later. Required: gnt stays 100 until hold_cnt = 3, then 001 on the following edge. A raised req1 never preempts req0.
- Release: owner drops req while another requester is pending. Required: the pending requester gets gnt one cycle later. With no one pending, gnt = 000 and the heartbeat returns.
- Mid-ownership reset: assert rst_n during SOLID ownership. Required: led = 111111 and gnt = 000 immediately (asynchronous). After release, re-grant follows the normal 1-cycle latency.
